spike_rate_decoder: RTL

Decodes a 1-bit spike train, such as a LIF neuron output, back into multi-bit quantities for downstream logic. It produces three outputs: a windowed spike-count rate, an exponentially decaying activity trace, and the inter-spike interval (ISI). It sits at the receiving end of a neuron's spike line and feeds weight-update or readout logic with the same 8-bit value scale the neurons consume.

---
 rtl/spike_rate_decoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: windowed spike-count rate, decaying activity trace and
// inter-spike interval, all on the 8-bit value scale the neurons consume.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_LOG2 = 4,
  parameter logic [7:0]  TRACE_INC   = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spike,
  input  logic       enable,
  output logic [7:0] rate,
  output logic       rate_valid,
  output logic [7:0] trace,
  output logic [7:0] isi,
  output logic       isi_valid,
  output logic       overflow
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WINDOW_LOG2-1:0] WIN_ONE = 1;

  state_t                 state;
  state_t                 state_nx;
  logic                   run_edge;
  logic                   window_end;
  logic [WINDOW_LOG2-1:0] window_cnt;
  logic [7:0]             acc;
  logic                   acc_sat;
  logic [7:0]             isi_cnt;
  logic                   seen_first;
  logic [8:0]             acc_sum;
  logic [8:0]             isi_sum;
  logic [8:0]             trace_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Only an edge that is already in RUN with enable still high decodes; the
  // entry edge and any enable=0 edge behave as IDLE.
  always_comb begin
    state_nx = state;
    run_edge = 1'b0;
    case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN: begin
        if (!enable) state_nx = IDLE;
        else         run_edge = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    window_end = run_edge && (window_cnt == '1);
    acc_sum    = {1'b0, acc} + {8'd0, spike};
    isi_sum    = {1'b0, isi_cnt} + 9'd1;
    trace_sum  = {1'b0, trace} - {3'b000, trace[7:2]}
               + ((spike && enable) ? {1'b0, TRACE_INC} : 9'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_cnt <= '0;
      acc        <= '0;
      acc_sat    <= 1'b0;
      isi_cnt    <= '0;
      seen_first <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      trace      <= '0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      trace      <= trace_sum[8] ? 8'hFF : trace_sum[7:0];

      if (!run_edge) begin
        window_cnt <= '0;
        acc        <= '0;
        acc_sat    <= 1'b0;
        isi_cnt    <= '0;
        seen_first <= 1'b0;
      end else begin
        window_cnt <= window_cnt + WIN_ONE;

        // acc_sat remembers an earlier clamp so a window that counted more than
        // 255 still flags overflow even if its last cycle carries no spike.
        if (window_end) begin
          rate       <= acc_sum[8] ? 8'hFF : acc_sum[7:0];
          rate_valid <= 1'b1;
          acc        <= '0;
          acc_sat    <= 1'b0;
          if (acc_sat || acc_sum[8]) overflow <= 1'b1;
        end else begin
          acc     <= acc_sum[8] ? 8'hFF : acc_sum[7:0];
          acc_sat <= acc_sat | acc_sum[8];
        end

        if (spike) begin
          if (seen_first) begin
            isi       <= isi_cnt;
            isi_valid <= 1'b1;
          end
          seen_first <= 1'b1;
          isi_cnt    <= 8'd1;
        end else begin
          isi_cnt <= isi_sum[8] ? 8'hFF : isi_sum[7:0];
          if (isi_sum >= 9'd255) overflow <= 1'b1;
        end
      end
    end
  end

endmodule
